// File: rtl/rv32_pkg.sv
// Shared RV32 control-transfer definitions: branch funct3 encodings,
// the redirect FSM state type and the default datapath width.
package rv32_pkg;

   localparam int XLEN = 32;

   localparam logic [2:0] F3_BEQ  = 3'b000;
   localparam logic [2:0] F3_BNE  = 3'b001;
   localparam logic [2:0] F3_BLT  = 3'b100;
   localparam logic [2:0] F3_BGE  = 3'b101;
   localparam logic [2:0] F3_BLTU = 3'b110;
   localparam logic [2:0] F3_BGEU = 3'b111;

   typedef enum logic {
      IDLE     = 1'b0,
      REDIRECT = 1'b1
   } br_state_t;

endpackage

// File: rtl/branch_cond_decode.sv
// Combinational branch condition: maps funct3 and comparator flags to taken.
// Reserved encodings (010/011) resolve as not taken.
module branch_cond_decode
   import rv32_pkg::*;
(
   input  logic [2:0] funct3,
   input  logic       cmp_neq,
   input  logic       cmp_lt,
   input  logic       cmp_ltu,
   output logic       taken
);

   always_comb begin
      taken = 1'b0;
      case (funct3)
         F3_BEQ:  taken = ~cmp_neq;
         F3_BNE:  taken =  cmp_neq;
         F3_BLT:  taken =  cmp_lt;
         F3_BGE:  taken = ~cmp_lt;
         F3_BLTU: taken =  cmp_ltu;
         F3_BGEU: taken = ~cmp_ltu;
         default: taken = 1'b0;
      endcase
   end

endmodule

// File: rtl/branch_resolve_unit.sv
// EX-stage branch/jump resolution: decides taken, computes the target and holds
// a registered redirect to fetch (with flush) until fetch accepts it.
module branch_resolve_unit #(
   parameter int XLEN  = 32,
   parameter int CNT_W = 32
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             ex_valid,
   input  logic             ex_stall,
   input  logic             ex_is_branch,
   input  logic             ex_is_jal,
   input  logic             ex_is_jalr,
   input  logic [2:0]       ex_funct3,
   input  logic [XLEN-1:0]  ex_pc,
   input  logic [XLEN-1:0]  ex_imm,
   input  logic [XLEN-1:0]  ex_rs1,
   input  logic             cmp_neq,
   input  logic             cmp_lt,
   input  logic             cmp_ltu,
   output logic             redirect_valid,
   output logic [XLEN-1:0]  redirect_pc,
   input  logic             redirect_ready,
   output logic             flush,
   output logic             misalign_exc,
   output logic [CNT_W-1:0] branch_cnt,
   output logic [CNT_W-1:0] taken_cnt
);
   import rv32_pkg::*;

   br_state_t       state;
   logic            cond_taken;
   logic            taken;
   logic            resolve;
   logic [XLEN-1:0] pc_sum;
   logic [XLEN-1:0] rs1_sum;
   logic [XLEN-1:0] target;

   branch_cond_decode u_cond (
      .funct3  (ex_funct3),
      .cmp_neq (cmp_neq),
      .cmp_lt  (cmp_lt),
      .cmp_ltu (cmp_ltu),
      .taken   (cond_taken)
   );

   assign resolve = (state == IDLE) & ex_valid & ~ex_stall
                  & (ex_is_branch | ex_is_jal | ex_is_jalr);

   // Adders wrap mod 2^XLEN; JALR clears bit 0 of its target.
   assign pc_sum  = ex_pc + ex_imm;
   assign rs1_sum = ex_rs1 + ex_imm;
   assign target  = ex_is_jalr ? {rs1_sum[XLEN-1:1], 1'b0} : pc_sum;
   assign taken   = ex_is_jal | ex_is_jalr | (ex_is_branch & cond_taken);

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state          <= IDLE;
         redirect_valid <= 1'b0;
         redirect_pc    <= '0;
         flush          <= 1'b0;
         misalign_exc   <= 1'b0;
         branch_cnt     <= '0;
         taken_cnt      <= '0;
      end else begin
         misalign_exc <= resolve & taken & target[1];
         if (resolve) branch_cnt <= branch_cnt + CNT_W'(1);
         case (state)
            IDLE: begin
               if (resolve && taken && !target[1]) begin
                  state          <= REDIRECT;
                  redirect_valid <= 1'b1;
                  flush          <= 1'b1;
                  redirect_pc    <= target;
                  taken_cnt      <= taken_cnt + CNT_W'(1);
               end
            end
            REDIRECT: begin
               // redirect_pc is held until fetch takes the redirect.
               if (redirect_ready) begin
                  state          <= IDLE;
                  redirect_valid <= 1'b0;
                  flush          <= 1'b0;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_branch_resolve_unit.sv
// Directed bench for branch_resolve_unit: a behavioural model is checked against
// the DUT every cycle, with literal expectations pinning key scenarios.
module tb_branch_resolve_unit;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        ex_valid, ex_stall, ex_is_branch, ex_is_jal, ex_is_jalr;
   logic [2:0]  ex_funct3;
   logic [31:0] ex_pc, ex_imm, ex_rs1;
   logic        cmp_neq, cmp_lt, cmp_ltu;
   logic        redirect_valid, redirect_ready, flush, misalign_exc;
   logic [31:0] redirect_pc, branch_cnt, taken_cnt;

   int total = 0;
   int bad   = 0;

   // model state
   logic        m_redir = 1'b0;
   logic [31:0] m_pc = '0;
   logic        m_mis = 1'b0;
   int unsigned m_bcnt = 0;
   int unsigned m_tcnt = 0;
   logic        model_on = 1'b0;

   always #5 clk = ~clk;

   branch_resolve_unit #(.XLEN(32), .CNT_W(32)) dut (
      .clk            (clk),
      .rst_n          (rst_n),
      .ex_valid       (ex_valid),
      .ex_stall       (ex_stall),
      .ex_is_branch   (ex_is_branch),
      .ex_is_jal      (ex_is_jal),
      .ex_is_jalr     (ex_is_jalr),
      .ex_funct3      (ex_funct3),
      .ex_pc          (ex_pc),
      .ex_imm         (ex_imm),
      .ex_rs1         (ex_rs1),
      .cmp_neq        (cmp_neq),
      .cmp_lt         (cmp_lt),
      .cmp_ltu        (cmp_ltu),
      .redirect_valid (redirect_valid),
      .redirect_pc    (redirect_pc),
      .redirect_ready (redirect_ready),
      .flush          (flush),
      .misalign_exc   (misalign_exc),
      .branch_cnt     (branch_cnt),
      .taken_cnt      (taken_cnt)
   );

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic logic cond_of(input logic [2:0] f3, input logic neq, lt, ltu);
      case (f3)
         3'd0: return !neq;
         3'd1: return neq;
         3'd4: return lt;
         3'd5: return !lt;
         3'd6: return ltu;
         3'd7: return !ltu;
         default: return 1'b0;
      endcase
   endfunction

   // Behavioural model: what the outputs must hold after each rising edge.
   always @(posedge clk) begin
      logic        tk;
      logic [31:0] tgt;
      if (!rst_n) begin
         m_redir = 0; m_pc = 0; m_mis = 0; m_bcnt = 0; m_tcnt = 0;
      end else begin
         m_mis = 0;
         if (m_redir) begin
            if (redirect_ready) m_redir = 0;
         end else if (ex_valid && !ex_stall && (ex_is_branch || ex_is_jal || ex_is_jalr)) begin
            m_bcnt++;
            tk  = (ex_is_jal || ex_is_jalr) ? 1'b1 : cond_of(ex_funct3, cmp_neq, cmp_lt, cmp_ltu);
            tgt = ex_is_jalr ? ((ex_rs1 + ex_imm) & 32'hFFFF_FFFE) : (ex_pc + ex_imm);
            if (tk) begin
               if (tgt[1]) m_mis = 1;
               else begin
                  m_redir = 1; m_pc = tgt; m_tcnt++;
               end
            end
         end
      end
   end

   always @(negedge clk) begin
      if (model_on) begin
         check("m_valid",  {31'd0, redirect_valid}, {31'd0, m_redir});
         check("m_flush",  {31'd0, flush},          {31'd0, m_redir});
         check("m_pc",     redirect_pc,             m_pc);
         check("m_misal",  {31'd0, misalign_exc},   {31'd0, m_mis});
         check("m_bcnt",   branch_cnt,              m_bcnt);
         check("m_tcnt",   taken_cnt,               m_tcnt);
      end
   end

   task automatic step();
      @(posedge clk); #1;
   endtask

   task automatic issue(input logic br, jal, jalr, input logic [2:0] f3,
                        input logic [31:0] pc, imm, rs1, input logic neq, lt, ltu);
      ex_valid = 1; ex_is_branch = br; ex_is_jal = jal; ex_is_jalr = jalr;
      ex_funct3 = f3; ex_pc = pc; ex_imm = imm; ex_rs1 = rs1;
      cmp_neq = neq; cmp_lt = lt; cmp_ltu = ltu;
      step();
      ex_valid = 0; ex_is_branch = 0; ex_is_jal = 0; ex_is_jalr = 0;
   endtask

   initial begin
      rst_n = 0; ex_valid = 0; ex_stall = 0; ex_is_branch = 0; ex_is_jal = 0;
      ex_is_jalr = 0; ex_funct3 = 0; ex_pc = 0; ex_imm = 0; ex_rs1 = 0;
      cmp_neq = 0; cmp_lt = 0; cmp_ltu = 0; redirect_ready = 1;
      step(); step();
      model_on = 1;
      check("rst_valid", {31'd0, redirect_valid}, 32'd0);
      check("rst_pc",    redirect_pc, 32'd0);
      check("rst_bcnt",  branch_cnt,  32'd0);
      rst_n = 1;
      step();

      // BEQ taken
      issue(1, 0, 0, 3'd0, 32'h100, 32'h20, 32'h0, 0, 0, 0);
      check("beq_valid", {31'd0, redirect_valid}, 32'd1);
      check("beq_flush", {31'd0, flush}, 32'd1);
      check("beq_pc",    redirect_pc, 32'h120);
      check("beq_tcnt",  taken_cnt, 32'd1);
      step();
      check("beq_done",  {31'd0, redirect_valid}, 32'd0);

      // BNE not taken
      issue(1, 0, 0, 3'd1, 32'h180, 32'h40, 32'h0, 0, 0, 0);
      check("bne_valid", {31'd0, redirect_valid}, 32'd0);
      check("bne_bcnt",  branch_cnt, 32'd2);
      check("bne_tcnt",  taken_cnt, 32'd1);

      // BGEU taken, fetch stalls the redirect three extra cycles
      redirect_ready = 0;
      issue(1, 0, 0, 3'd7, 32'h200, 32'h40, 32'h0, 1, 1, 0);
      for (int i = 0; i < 4; i++) begin
         check("bgeu_hold_v",  {31'd0, redirect_valid}, 32'd1);
         check("bgeu_hold_pc", redirect_pc, 32'h240);
         if (i < 3) step();
      end
      redirect_ready = 1;
      step();
      check("bgeu_drop", {31'd0, redirect_valid}, 32'd0);

      // JALR to misaligned target
      issue(0, 0, 1, 3'd0, 32'h300, 32'h0, 32'h1003, 0, 0, 0);
      check("mis_pulse", {31'd0, misalign_exc}, 32'd1);
      check("mis_nored", {31'd0, redirect_valid}, 32'd0);
      check("mis_tcnt",  taken_cnt, 32'd2);
      step();
      check("mis_end",   {31'd0, misalign_exc}, 32'd0);

      // JALR clears bit 0
      issue(0, 0, 1, 3'd0, 32'h300, 32'h3, 32'h2001, 0, 0, 0);
      check("jalr_pc", redirect_pc, 32'h2004);
      step();

      // JAL wraps past 2^32; a second jump during REDIRECT is squashed
      redirect_ready = 0;
      issue(0, 1, 0, 3'd0, 32'hFFFF_FFFC, 32'h8, 32'h0, 0, 0, 0);
      check("jal_pc", redirect_pc, 32'h4);
      issue(0, 1, 0, 3'd0, 32'h0, 32'h100, 32'h0, 0, 0, 0);
      check("squash_pc",   redirect_pc, 32'h4);
      check("squash_bcnt", branch_cnt, 32'd6);
      redirect_ready = 1;
      step();

      // Reserved funct3 010: counted, not taken
      issue(1, 0, 0, 3'd2, 32'h400, 32'h10, 32'h0, 0, 0, 0);
      check("rsv_valid", {31'd0, redirect_valid}, 32'd0);
      check("rsv_mis",   {31'd0, misalign_exc}, 32'd0);

      // BLT held in EX by a two-cycle stall: one resolve
      ex_stall = 1;
      ex_valid = 1; ex_is_branch = 1; ex_funct3 = 3'd4; ex_pc = 32'h500;
      ex_imm = 32'h8; cmp_lt = 1; cmp_neq = 1; cmp_ltu = 0;
      step(); step();
      check("stall_none", {31'd0, redirect_valid}, 32'd0);
      ex_stall = 0;
      issue(1, 0, 0, 3'd4, 32'h500, 32'h8, 32'h0, 1, 1, 0);
      check("stall_bcnt", branch_cnt, 32'd8);
      check("stall_pc",   redirect_pc, 32'h508);
      step();

      // Reset during REDIRECT drops everything
      redirect_ready = 0;
      issue(1, 0, 0, 3'd0, 32'h600, 32'h10, 32'h0, 0, 0, 0);
      rst_n = 0;
      step();
      check("rst2_valid", {31'd0, redirect_valid}, 32'd0);
      check("rst2_flush", {31'd0, flush}, 32'd0);
      check("rst2_tcnt",  taken_cnt, 32'd0);
      check("rst2_pc",    redirect_pc, 32'd0);
      rst_n = 1; redirect_ready = 1;
      step(); step();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
